// File: rtl/target_position_gen_if.sv
// Request/result bundle between the game controller and the target generator.
// The controller holds the master side; the generator holds the slave side.
interface target_position_gen_if #(
    parameter int H_WIDTH = 8,
    parameter int V_WIDTH = 7
);
    logic               CLEAR;
    logic               ENABLE;
    logic               REQ;
    logic [H_WIDTH-1:0] EXCL_H;
    logic [V_WIDTH-1:0] EXCL_V;
    logic [H_WIDTH-1:0] TARGET_H;
    logic [V_WIDTH-1:0] TARGET_V;
    logic               VALID;
    logic               BUSY;

    modport master (
        output CLEAR, ENABLE, REQ, EXCL_H, EXCL_V,
        input  TARGET_H, TARGET_V, VALID, BUSY
    );

    modport slave (
        input  CLEAR, ENABLE, REQ, EXCL_H, EXCL_V,
        output TARGET_H, TARGET_V, VALID, BUSY
    );
endinterface

// File: rtl/target_position_gen.sv
// Random target generator: two free-running XNOR LFSRs feed a draw/check FSM
// that rejects off-area or excluded cells, with a deterministic in-range fallback.
module target_position_gen #(
    parameter int                 H_WIDTH   = 8,
    parameter int                 V_WIDTH   = 7,
    parameter int                 H_MAX     = 160,
    parameter int                 V_MAX     = 120,
    parameter logic [H_WIDTH-1:0] H_TAPS    = 8'hB8,
    parameter logic [V_WIDTH-1:0] V_TAPS    = 7'h60,
    parameter logic [H_WIDTH-1:0] H_SEED    = 8'd50,
    parameter logic [V_WIDTH-1:0] V_SEED    = 7'd50,
    parameter logic [H_WIDTH-1:0] DEF_H     = 8'd80,
    parameter logic [V_WIDTH-1:0] DEF_V     = 7'd60,
    parameter int                 MAX_TRIES = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    target_position_gen_if.slave  bus
);

    localparam int                 TRIES_W     = $clog2(MAX_TRIES + 1);
    localparam logic [TRIES_W-1:0] TRIES_LIMIT = TRIES_W'(MAX_TRIES);
    localparam logic [TRIES_W-1:0] TRIES_ONE   = TRIES_W'(1'b1);
    localparam logic [TRIES_W-1:0] TRIES_ZERO  = {TRIES_W{1'b0}};

    // One extra bit so H_MAX == 2**H_WIDTH still compares correctly
    localparam int                 HX_W    = H_WIDTH + 1;
    localparam int                 VX_W    = V_WIDTH + 1;
    localparam logic [HX_W-1:0]    H_MAX_X = HX_W'(H_MAX);
    localparam logic [VX_W-1:0]    V_MAX_X = VX_W'(V_MAX);
    localparam logic [H_WIDTH-1:0] H_MAX_T = H_WIDTH'(H_MAX);
    localparam logic [V_WIDTH-1:0] V_MAX_T = V_WIDTH'(V_MAX);
    localparam logic [H_WIDTH-1:0] H_LAST  = H_WIDTH'(H_MAX - 1);
    localparam logic [H_WIDTH-1:0] H_ONE   = H_WIDTH'(1'b1);
    localparam logic [H_WIDTH-1:0] H_ZERO  = {H_WIDTH{1'b0}};
    localparam logic [V_WIDTH-1:0] V_ZERO  = {V_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t               state_r;
    state_t               next_state_s;
    logic [TRIES_W-1:0]   tries_r;
    logic [TRIES_W-1:0]   tries_nxt_s;
    logic                 busy_r;
    logic                 busy_nxt_s;

    logic [H_WIDTH-1:0]   h_lfsr_r;
    logic [V_WIDTH-1:0]   v_lfsr_r;
    logic [H_WIDTH-1:0]   cand_h_r;
    logic [V_WIDTH-1:0]   cand_v_r;
    logic                 cand_load_s;

    logic [H_WIDTH-1:0]   target_h_r;
    logic [V_WIDTH-1:0]   target_v_r;
    logic                 valid_r;
    logic [H_WIDTH-1:0]   target_h_nxt_s;
    logic [V_WIDTH-1:0]   target_v_nxt_s;
    logic                 valid_nxt_s;

    logic                 h_in_range_s;
    logic                 v_in_range_s;
    logic                 accept_s;
    logic [H_WIDTH-1:0]   fold_h_s;
    logic [V_WIDTH-1:0]   fold_v_s;
    logic [H_WIDTH-1:0]   fb_h_s;

    function automatic logic [H_WIDTH-1:0] h_step(input logic [H_WIDTH-1:0] l);
        return {l[H_WIDTH-2:0], ~^(l & H_TAPS)};
    endfunction

    function automatic logic [V_WIDTH-1:0] v_step(input logic [V_WIDTH-1:0] l);
        return {l[V_WIDTH-2:0], ~^(l & V_TAPS)};
    endfunction

    // Free-running coordinate LFSRs; seeds are never all-ones so lock-up cannot occur
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            h_lfsr_r <= H_SEED;
            v_lfsr_r <= V_SEED;
        end else if (bus.CLEAR) begin
            h_lfsr_r <= H_SEED;
            v_lfsr_r <= V_SEED;
        end else if (bus.ENABLE) begin
            h_lfsr_r <= h_step(h_lfsr_r);
            v_lfsr_r <= v_step(v_lfsr_r);
        end else begin
            h_lfsr_r <= h_lfsr_r;
            v_lfsr_r <= v_lfsr_r;
        end
    end

    // Range and exclusion test on the latched candidate
    always_comb begin
        h_in_range_s = ({1'b0, cand_h_r} < H_MAX_X);
        v_in_range_s = ({1'b0, cand_v_r} < V_MAX_X);
        accept_s     = h_in_range_s && v_in_range_s &&
                       !((cand_h_r == bus.EXCL_H) && (cand_v_r == bus.EXCL_V));
    end

    // Fallback: fold each axis back into the area, then step H off the excluded cell
    always_comb begin
        fold_h_s = cand_h_r;
        fold_v_s = cand_v_r;
        fb_h_s   = cand_h_r;
        if (h_in_range_s) begin
            fold_h_s = cand_h_r;
        end else begin
            fold_h_s = cand_h_r - H_MAX_T;
        end
        if (v_in_range_s) begin
            fold_v_s = cand_v_r;
        end else begin
            fold_v_s = cand_v_r - V_MAX_T;
        end
        if ((fold_h_s == bus.EXCL_H) && (fold_v_s == bus.EXCL_V)) begin
            if (fold_h_s == H_LAST) begin
                fb_h_s = H_ZERO;
            end else begin
                fb_h_s = fold_h_s + H_ONE;
            end
        end else begin
            fb_h_s = fold_h_s;
        end
    end

    // Next-state and result selection for the request FSM
    always_comb begin
        next_state_s   = state_r;
        tries_nxt_s    = tries_r;
        cand_load_s    = 1'b0;
        valid_nxt_s    = 1'b0;
        target_h_nxt_s = target_h_r;
        target_v_nxt_s = target_v_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.REQ) begin
                    next_state_s = ST_DRAW;
                    tries_nxt_s  = TRIES_ZERO;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DRAW: begin
                cand_load_s  = 1'b1;
                tries_nxt_s  = tries_r + TRIES_ONE;
                next_state_s = ST_CHECK;
            end
            ST_CHECK: begin
                if (accept_s) begin
                    target_h_nxt_s = cand_h_r;
                    target_v_nxt_s = cand_v_r;
                    valid_nxt_s    = 1'b1;
                    next_state_s   = ST_IDLE;
                end else if (tries_r < TRIES_LIMIT) begin
                    next_state_s   = ST_DRAW;
                end else begin
                    target_h_nxt_s = fb_h_s;
                    target_v_nxt_s = fold_v_s;
                    valid_nxt_s    = 1'b1;
                    next_state_s   = ST_IDLE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                tries_nxt_s  = TRIES_ZERO;
            end
        endcase
        busy_nxt_s = (next_state_s != ST_IDLE);
    end

    // FSM state, draw counter and busy flag
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
            tries_r <= TRIES_ZERO;
            busy_r  <= 1'b0;
        end else if (bus.CLEAR) begin
            state_r <= ST_IDLE;
            tries_r <= TRIES_ZERO;
            busy_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            tries_r <= tries_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    // Candidate latch, captured from the LFSRs in DRAW
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cand_h_r <= H_ZERO;
            cand_v_r <= V_ZERO;
        end else if (bus.CLEAR) begin
            cand_h_r <= H_ZERO;
            cand_v_r <= V_ZERO;
        end else if (cand_load_s) begin
            cand_h_r <= h_lfsr_r;
            cand_v_r <= v_lfsr_r;
        end else begin
            cand_h_r <= cand_h_r;
            cand_v_r <= cand_v_r;
        end
    end

    // Published target and its one-cycle valid strobe
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            target_h_r <= DEF_H;
            target_v_r <= DEF_V;
            valid_r    <= 1'b0;
        end else if (bus.CLEAR) begin
            target_h_r <= DEF_H;
            target_v_r <= DEF_V;
            valid_r    <= 1'b0;
        end else begin
            target_h_r <= target_h_nxt_s;
            target_v_r <= target_v_nxt_s;
            valid_r    <= valid_nxt_s;
        end
    end

    assign bus.TARGET_H = target_h_r;
    assign bus.TARGET_V = target_v_r;
    assign bus.VALID    = valid_r;
    assign bus.BUSY     = busy_r;

endmodule

// File: tb/tb_target_position_gen.sv
// Bench for target_position_gen: fixed-seed instances for directed corner cases and
// a main instance checked against an array-based reference of the LFSR sequences.
module tb_target_position_gen;

    logic CLK;
    logic RESET;
    int   errors;
    int   checks;
    int   steps;

    logic [7:0] hseq [0:254];
    logic [6:0] vseq [0:126];

    target_position_gen_if #(.H_WIDTH(8), .V_WIDTH(7)) m_if (), a_if (), b_if (), c_if ();

    target_position_gen u_main (.CLK(CLK), .RESET(RESET), .bus(m_if.slave));
    target_position_gen #(.H_SEED(8'd30), .V_SEED(7'd40)) u_a (.CLK(CLK), .RESET(RESET), .bus(a_if.slave));
    target_position_gen #(.H_SEED(8'd200), .V_SEED(7'd50)) u_b (.CLK(CLK), .RESET(RESET), .bus(b_if.slave));
    target_position_gen #(.H_SEED(8'd159), .V_SEED(7'd50), .MAX_TRIES(1)) u_c (.CLK(CLK), .RESET(RESET), .bus(c_if.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Number of LFSR steps the main instance has taken since its last reset/clear
    always @(posedge CLK or posedge RESET) begin
        if (RESET) steps <= 0;
        else if (m_if.CLEAR) steps <= 0;
        else if (m_if.ENABLE) steps <= steps + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic build_seq();
        hseq[0] = 8'd50;
        vseq[0] = 7'd50;
        for (int i = 1; i < 255; i++) hseq[i] = {hseq[i-1][6:0], ~^(hseq[i-1] & 8'hB8)};
        for (int i = 1; i < 127; i++) vseq[i] = {vseq[i-1][5:0], ~^(vseq[i-1] & 7'h60)};
    endtask

    // Outcome of a request on the main instance whose REQ edge left the LFSRs at step s
    function automatic void predict(input int s, input bit en, input logic [7:0] eh, input logic [6:0] ev,
                                    output logic [7:0] th, output logic [6:0] tv, output int lat);
        logic [7:0] ch;
        logic [6:0] cv;
        int fh, fv, k;
        ch = 8'd0; cv = 7'd0;
        for (int j = 0; j < 4; j++) begin
            k = en ? s + 2 * j : s;
            ch = hseq[k % 255];
            cv = vseq[k % 127];
            lat = 2 * (j + 1);
            if (ch < 8'd160 && cv < 7'd120 && !(ch == eh && cv == ev)) begin
                th = ch; tv = cv;
                return;
            end
        end
        fh = (ch >= 8'd160) ? int'(ch) - 160 : int'(ch);
        fv = (cv >= 7'd120) ? int'(cv) - 120 : int'(cv);
        if (fh == int'(eh) && fv == int'(ev)) fh = (fh == 159) ? 0 : fh + 1;
        th = 8'(fh);
        tv = 7'(fv);
    endfunction

    task automatic run_req(output int s, output int lat);
        int e;
        m_if.REQ = 1'b1;
        tick();
        s = steps;
        m_if.REQ = 1'b0;
        e = 0;
        lat = 0;
        while (lat == 0 && e < 20) begin
            tick();
            e++;
            if (m_if.VALID === 1'b1) lat = e;
        end
    endtask

    task automatic test_reset();
        int s, lat, nval;
        checks++;
        if (m_if.TARGET_H !== 8'd80 || m_if.TARGET_V !== 7'd60) begin
            errors++; $display("FAIL reset_target: got (%0d,%0d) required (80,60)", m_if.TARGET_H, m_if.TARGET_V);
        end
        checks++;
        if (m_if.VALID !== 1'b0 || m_if.BUSY !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got valid=%b busy=%b required 0/0", m_if.VALID, m_if.BUSY);
        end
        checks++;
        if (a_if.TARGET_H !== 8'd80 || b_if.TARGET_H !== 8'd80 || c_if.TARGET_H !== 8'd80 ||
            a_if.TARGET_V !== 7'd60 || b_if.TARGET_V !== 7'd60 || c_if.TARGET_V !== 7'd60) begin
            errors++; $display("FAIL reset_others: got a=(%0d,%0d) b=(%0d,%0d) c=(%0d,%0d) required (80,60)",
                               a_if.TARGET_H, a_if.TARGET_V, b_if.TARGET_H, b_if.TARGET_V, c_if.TARGET_H, c_if.TARGET_V);
        end
        run_req(s, lat);
        checks++;
        if (m_if.TARGET_H !== 8'd50 || m_if.TARGET_V !== 7'd50 || lat != 2) begin
            errors++; $display("FAIL seed_draw: got (%0d,%0d) lat=%0d required (50,50) lat=2", m_if.TARGET_H, m_if.TARGET_V, lat);
        end
        m_if.REQ = 1'b1;
        tick();
        m_if.REQ = 1'b0;
        checks++;
        if (m_if.BUSY !== 1'b1) begin
            errors++; $display("FAIL busy_in_request: got %b required 1", m_if.BUSY);
        end
        #3 RESET = 1'b1;
        #1;
        checks++;
        if (m_if.TARGET_H !== 8'd80 || m_if.TARGET_V !== 7'd60) begin
            errors++; $display("FAIL async_reset_target: got (%0d,%0d) required (80,60)", m_if.TARGET_H, m_if.TARGET_V);
        end
        checks++;
        if (m_if.BUSY !== 1'b0 || m_if.VALID !== 1'b0) begin
            errors++; $display("FAIL async_reset_flags: got busy=%b valid=%b required 0/0", m_if.BUSY, m_if.VALID);
        end
        #2 RESET = 1'b0;
        nval = 0;
        repeat (10) begin
            tick();
            if (m_if.VALID === 1'b1) nval++;
        end
        checks++;
        if (nval != 0) begin
            errors++; $display("FAIL reset_abort: got %0d valid pulses required 0", nval);
        end
    endtask

    task automatic test_accept_first();
        int e, lat;
        a_if.EXCL_H = 8'd0; a_if.EXCL_V = 7'd0;
        a_if.REQ = 1'b1;
        tick();
        a_if.REQ = 1'b0;
        checks++;
        if (a_if.BUSY !== 1'b1) begin
            errors++; $display("FAIL accept_busy: got %b required 1", a_if.BUSY);
        end
        e = 0; lat = 0;
        while (lat == 0 && e < 20) begin
            tick(); e++;
            if (a_if.VALID === 1'b1) lat = e;
        end
        checks++;
        if (lat != 2 || a_if.TARGET_H !== 8'd30 || a_if.TARGET_V !== 7'd40) begin
            errors++; $display("FAIL accept_first: got (%0d,%0d) lat=%0d required (30,40) lat=2", a_if.TARGET_H, a_if.TARGET_V, lat);
        end
        checks++;
        if (a_if.BUSY !== 1'b0) begin
            errors++; $display("FAIL accept_busy_done: got %b required 0", a_if.BUSY);
        end
        tick();
        checks++;
        if (a_if.VALID !== 1'b0 || a_if.TARGET_H !== 8'd30 || a_if.TARGET_V !== 7'd40) begin
            errors++; $display("FAIL accept_hold: got valid=%b (%0d,%0d) required 0 (30,40)", a_if.VALID, a_if.TARGET_H, a_if.TARGET_V);
        end
    endtask

    task automatic test_fallback();
        int e, lat;
        logic [7:0] exh [0:1];
        logic [7:0] wanth [0:1];
        exh[0] = 8'd0;  wanth[0] = 8'd40;
        exh[1] = 8'd40; wanth[1] = 8'd41;
        for (int r = 0; r < 2; r++) begin
            b_if.EXCL_H = exh[r]; b_if.EXCL_V = 7'd50;
            b_if.REQ = 1'b1;
            tick();
            b_if.REQ = 1'b0;
            e = 0; lat = 0;
            while (lat == 0 && e < 20) begin
                tick(); e++;
                if (b_if.VALID === 1'b1) lat = e;
            end
            checks++;
            if (lat != 8 || b_if.TARGET_H !== wanth[r] || b_if.TARGET_V !== 7'd50) begin
                errors++; $display("FAIL fallback_%0d: got (%0d,%0d) lat=%0d required (%0d,50) lat=8",
                                   r, b_if.TARGET_H, b_if.TARGET_V, lat, wanth[r]);
            end
        end
    endtask

    task automatic test_wrap();
        int e, lat;
        logic [7:0] exh [0:1];
        logic [7:0] wanth [0:1];
        exh[0] = 8'd159; wanth[0] = 8'd0;
        exh[1] = 8'd0;   wanth[1] = 8'd159;
        for (int r = 0; r < 2; r++) begin
            c_if.EXCL_H = exh[r]; c_if.EXCL_V = 7'd50;
            c_if.REQ = 1'b1;
            tick();
            c_if.REQ = 1'b0;
            e = 0; lat = 0;
            while (lat == 0 && e < 20) begin
                tick(); e++;
                if (c_if.VALID === 1'b1) lat = e;
            end
            checks++;
            if (lat != 2 || c_if.TARGET_H !== wanth[r] || c_if.TARGET_V !== 7'd50) begin
                errors++; $display("FAIL wrap_%0d: got (%0d,%0d) lat=%0d required (%0d,50) lat=2",
                                   r, c_if.TARGET_H, c_if.TARGET_V, lat, wanth[r]);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int nval, first;
        b_if.EXCL_H = 8'd0; b_if.EXCL_V = 7'd0;
        b_if.REQ = 1'b1;
        tick();
        nval = 0; first = 0;
        for (int i = 1; i <= 20; i++) begin
            b_if.REQ = (i < 8);
            tick();
            if (b_if.VALID === 1'b1) begin
                nval++;
                if (first == 0) first = i;
            end
        end
        b_if.REQ = 1'b0;
        checks++;
        if (nval != 1 || first != 8) begin
            errors++; $display("FAIL ignore_busy: got %0d pulses first at %0d required 1 pulse at 8", nval, first);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] vmask;
        logic [7:0] th;
        logic [6:0] tv;
        int elat;
        m_if.ENABLE = 1'b0; m_if.EXCL_H = 8'd0; m_if.EXCL_V = 7'd0;
        vmask = 10'd0;
        m_if.REQ = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_if.VALID === 1'b1) vmask[i] = 1'b1;
        end
        m_if.REQ = 1'b0;
        repeat (4) tick();
        checks++;
        if (vmask !== 10'h124) begin
            errors++; $display("FAIL back_to_back: got valid mask %b required %b", vmask, 10'h124);
        end
        predict(steps, 1'b0, 8'd0, 7'd0, th, tv, elat);
        checks++;
        if (m_if.TARGET_H !== th || m_if.TARGET_V !== tv) begin
            errors++; $display("FAIL back_to_back_target: got (%0d,%0d) required (%0d,%0d)", m_if.TARGET_H, m_if.TARGET_V, th, tv);
        end
    endtask

    task automatic test_lfsr_period();
        int s, lat, elat, nst;
        logic [7:0] th;
        logic [6:0] tv;
        m_if.EXCL_H = 8'd0; m_if.EXCL_V = 7'd0;
        for (int r = 0; r < 3; r++) begin
            nst = (r == 0) ? 255 : (r == 1) ? 127 : 254;
            m_if.ENABLE = 1'b1;
            m_if.CLEAR = 1'b1;
            tick();
            m_if.CLEAR = 1'b0;
            repeat (nst) tick();
            m_if.ENABLE = 1'b0;
            run_req(s, lat);
            predict(s, 1'b0, 8'd0, 7'd0, th, tv, elat);
            checks++;
            if (lat != elat || m_if.TARGET_H !== th || m_if.TARGET_V !== tv) begin
                errors++; $display("FAIL lfsr_period_%0d: got (%0d,%0d) lat=%0d required (%0d,%0d) lat=%0d",
                                   nst, m_if.TARGET_H, m_if.TARGET_V, lat, th, tv, elat);
            end
        end
    endtask

    task automatic test_random();
        int s, lat, elat, gap;
        logic [7:0] th, eh;
        logic [6:0] tv, ev;
        m_if.ENABLE = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            gap = int'($urandom_range(0, 2));
            repeat (gap) tick();
            if ($urandom_range(0, 2) == 0) begin
                m_if.EXCL_H = hseq[(steps + 1) % 255];
                m_if.EXCL_V = vseq[(steps + 1) % 127];
            end else begin
                m_if.EXCL_H = 8'($urandom_range(0, 255));
                m_if.EXCL_V = 7'($urandom_range(0, 127));
            end
            eh = m_if.EXCL_H; ev = m_if.EXCL_V;
            run_req(s, lat);
            predict(s, 1'b1, eh, ev, th, tv, elat);
            checks++;
            if (lat != elat) begin
                errors++; $display("FAIL random_latency[%0d]: got %0d required %0d", n, lat, elat);
            end
            checks++;
            if (m_if.TARGET_H !== th || m_if.TARGET_V !== tv) begin
                errors++; $display("FAIL random_target[%0d]: got (%0d,%0d) required (%0d,%0d)", n, m_if.TARGET_H, m_if.TARGET_V, th, tv);
            end
            checks++;
            if (!(m_if.TARGET_H < 8'd160 && m_if.TARGET_V < 7'd120) || (m_if.TARGET_H == eh && m_if.TARGET_V == ev)) begin
                errors++; $display("FAIL random_legal[%0d]: got (%0d,%0d) required in range and not (%0d,%0d)",
                                   n, m_if.TARGET_H, m_if.TARGET_V, eh, ev);
            end
        end
        m_if.ENABLE = 1'b0;
    endtask

    task automatic test_clear();
        int s, lat, elat, nval;
        logic [7:0] th;
        logic [6:0] tv;
        m_if.ENABLE = 1'b1;
        repeat (7) tick();
        m_if.ENABLE = 1'b0;
        m_if.EXCL_H = 8'd0; m_if.EXCL_V = 7'd0;
        run_req(s, lat);
        predict(s, 1'b0, 8'd0, 7'd0, th, tv, elat);
        checks++;
        if (lat != elat || m_if.TARGET_H !== th || m_if.TARGET_V !== tv) begin
            errors++; $display("FAIL pre_clear: got (%0d,%0d) lat=%0d required (%0d,%0d) lat=%0d",
                               m_if.TARGET_H, m_if.TARGET_V, lat, th, tv, elat);
        end
        m_if.REQ = 1'b1;
        tick();
        m_if.REQ = 1'b0;
        m_if.CLEAR = 1'b1;
        tick();
        m_if.CLEAR = 1'b0;
        checks++;
        if (m_if.TARGET_H !== 8'd80 || m_if.TARGET_V !== 7'd60) begin
            errors++; $display("FAIL clear_target: got (%0d,%0d) required (80,60)", m_if.TARGET_H, m_if.TARGET_V);
        end
        checks++;
        if (m_if.BUSY !== 1'b0 || m_if.VALID !== 1'b0) begin
            errors++; $display("FAIL clear_flags: got busy=%b valid=%b required 0/0", m_if.BUSY, m_if.VALID);
        end
        nval = 0;
        repeat (10) begin
            tick();
            if (m_if.VALID === 1'b1) nval++;
        end
        checks++;
        if (nval != 0) begin
            errors++; $display("FAIL clear_abort: got %0d valid pulses required 0", nval);
        end
        run_req(s, lat);
        checks++;
        if (lat != 2 || m_if.TARGET_H !== 8'd50 || m_if.TARGET_V !== 7'd50) begin
            errors++; $display("FAIL clear_seeds: got (%0d,%0d) lat=%0d required (50,50) lat=2", m_if.TARGET_H, m_if.TARGET_V, lat);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        errors = 0;
        checks = 0;
        RESET = 1'b1;
        m_if.CLEAR = 1'b0; m_if.ENABLE = 1'b0; m_if.REQ = 1'b0; m_if.EXCL_H = 8'd0; m_if.EXCL_V = 7'd0;
        a_if.CLEAR = 1'b0; a_if.ENABLE = 1'b0; a_if.REQ = 1'b0; a_if.EXCL_H = 8'd0; a_if.EXCL_V = 7'd0;
        b_if.CLEAR = 1'b0; b_if.ENABLE = 1'b0; b_if.REQ = 1'b0; b_if.EXCL_H = 8'd0; b_if.EXCL_V = 7'd0;
        c_if.CLEAR = 1'b0; c_if.ENABLE = 1'b0; c_if.REQ = 1'b0; c_if.EXCL_H = 8'd0; c_if.EXCL_V = 7'd0;
        build_seq();
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        test_reset();
        test_accept_first();
        test_fallback();
        test_wrap();
        test_ignore_busy();
        test_back_to_back();
        test_lfsr_period();
        test_random();
        test_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
